// File: rtl/out_skew_sequencer.sv
// out_skew_sequencer: skewed vector feeder and phase controller for the output-stationary PE array
// Ports:
//   w_clock, w_reset            clock, synchronous active-high reset
//   w_start, w_k_len            tile start pulse (IDLE only) and reduction length
//   w_vec_valid, w_vec_ready    upstream handshake for one input/weight vector pair
//   w_vec_inp, w_vec_wgt        unskewed input (per row) and weight (per column) vectors
//   w_row_inp, w_col_wgt        diagonally skewed lanes to the left/top array edges
//   w_pe_ready, w_pe_rw         array enable (0 clears accumulators) and MAC/hold select
//   w_pe_stream                 PE stream select, tied low
//   w_capture, w_done, w_busy   scratchpad-visible pulse, tile-complete pulse, not-idle flag
module out_skew_sequencer #(
    parameter int ROWS                = 4,
    parameter int COLS                = 4,
    parameter int OUT_PE_INPUT_WIDTH  = 8,
    parameter int OUT_PE_WEIGHT_WIDTH = 8,
    parameter int K_MAX               = 256,
    parameter int KW                  = $clog2(K_MAX + 1)
) (
    input  logic                                w_clock,
    input  logic                                w_reset,
    input  logic                                w_start,
    input  logic [KW-1:0]                       w_k_len,
    input  logic                                w_vec_valid,
    output logic                                w_vec_ready,
    input  logic [ROWS*OUT_PE_INPUT_WIDTH-1:0]  w_vec_inp,
    input  logic [COLS*OUT_PE_WEIGHT_WIDTH-1:0] w_vec_wgt,
    output logic [ROWS*OUT_PE_INPUT_WIDTH-1:0]  w_row_inp,
    output logic [COLS*OUT_PE_WEIGHT_WIDTH-1:0] w_col_wgt,
    output logic                                w_pe_ready,
    output logic                                w_pe_rw,
    output logic                                w_pe_stream,
    output logic                                w_capture,
    output logic                                w_busy,
    output logic                                w_done
);
    localparam int IW = OUT_PE_INPUT_WIDTH;
    localparam int WW = OUT_PE_WEIGHT_WIDTH;
    localparam logic [KW-1:0] K_CAP = KW'(K_MAX);
    // FLUSH counts down from ROWS+COLS to 0 inclusive, giving ROWS+COLS+1 cycles
    localparam logic [KW-1:0] FLUSH_TOP = KW'(ROWS + COLS);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE} state_t;

    state_t        state, state_n;
    logic [KW-1:0] k_q, k_n, cnt, cnt_n;
    logic          xfer, shift;

    assign xfer        = (state == FEED) && w_vec_valid && w_vec_ready;
    assign shift       = (state_n == FEED) || (state_n == FLUSH);
    assign w_pe_stream = 1'b0;

    // cnt is the accepted-vector count in FEED and the flush down-counter in FLUSH
    always_comb begin
        state_n = state;
        k_n     = k_q;
        cnt_n   = cnt;
        case (state)
            IDLE: if (w_start) begin
                state_n = CLEAR;
                k_n     = (w_k_len > K_CAP) ? K_CAP : w_k_len;
                cnt_n   = '0;
            end
            CLEAR: state_n = (k_q != '0) ? FEED : DRAIN;
            FEED: if (xfer) begin
                state_n = (cnt + 1'b1 == k_q) ? FLUSH : FEED;
                cnt_n   = (cnt + 1'b1 == k_q) ? FLUSH_TOP : cnt + 1'b1;
            end
            FLUSH: begin
                state_n = (cnt == '0) ? DRAIN : FLUSH;
                cnt_n   = (cnt == '0) ? cnt : cnt - 1'b1;
            end
            DRAIN:   state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Control outputs are registered decodes of the state being entered
    always_ff @(posedge w_clock) begin
        if (w_reset) begin
            state       <= IDLE;
            k_q         <= '0;
            cnt         <= '0;
            w_vec_ready <= 1'b0;
            w_pe_ready  <= 1'b0;
            w_pe_rw     <= 1'b0;
            w_capture   <= 1'b0;
            w_busy      <= 1'b0;
            w_done      <= 1'b0;
        end else begin
            state       <= state_n;
            k_q         <= k_n;
            cnt         <= cnt_n;
            w_vec_ready <= (state_n == FEED) && (cnt_n < k_n);
            w_pe_ready  <= state_n inside {FEED, FLUSH, DRAIN, DONE};
            w_pe_rw     <= state_n inside {FEED, FLUSH};
            w_capture   <= state_n == DRAIN;
            w_busy      <= state_n != IDLE;
            w_done      <= state_n == DONE;
        end
    end

    // Row lane r delays element r by r+1 cycles; bubbles shift in zeros
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [IW-1:0] lane [0:r];
        always_ff @(posedge w_clock) begin
            if (w_reset || !shift) begin
                for (int i = 0; i <= r; i++) lane[i] <= '0;
            end else begin
                lane[0] <= xfer ? w_vec_inp[r*IW +: IW] : '0;
                for (int i = 1; i <= r; i++) lane[i] <= lane[i-1];
            end
        end
        assign w_row_inp[r*IW +: IW] = lane[r];
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        logic [WW-1:0] lane [0:c];
        always_ff @(posedge w_clock) begin
            if (w_reset || !shift) begin
                for (int i = 0; i <= c; i++) lane[i] <= '0;
            end else begin
                lane[0] <= xfer ? w_vec_wgt[c*WW +: WW] : '0;
                for (int i = 1; i <= c; i++) lane[i] <= lane[i-1];
            end
        end
        assign w_col_wgt[c*WW +: WW] = lane[c];
    end
endmodule

// File: tb/tb_out_skew_sequencer.sv
// tb_out_skew_sequencer: randomized and directed checks of out_skew_sequencer against a timeline model
module tb_out_skew_sequencer;
    localparam int ROWS  = 2;
    localparam int COLS  = 2;
    localparam int IW    = 8;
    localparam int WW    = 8;
    localparam int K_MAX = 256;
    localparam int KW    = $clog2(K_MAX + 1);
    localparam int RC    = ROWS + COLS;

    logic                 w_clock = 1'b0;
    logic                 w_reset = 1'b1;
    logic                 w_start = 1'b0;
    logic [KW-1:0]        w_k_len = '0;
    logic                 w_vec_valid = 1'b0;
    logic                 w_vec_ready;
    logic [ROWS*IW-1:0]   w_vec_inp = '0;
    logic [COLS*WW-1:0]   w_vec_wgt = '0;
    logic [ROWS*IW-1:0]   w_row_inp;
    logic [COLS*WW-1:0]   w_col_wgt;
    logic                 w_pe_ready, w_pe_rw, w_pe_stream, w_capture, w_busy, w_done;

    always #5 w_clock = ~w_clock;

    out_skew_sequencer #(
        .ROWS(ROWS), .COLS(COLS), .OUT_PE_INPUT_WIDTH(IW), .OUT_PE_WEIGHT_WIDTH(WW), .K_MAX(K_MAX)
    ) dut (
        .w_clock(w_clock), .w_reset(w_reset), .w_start(w_start), .w_k_len(w_k_len),
        .w_vec_valid(w_vec_valid), .w_vec_ready(w_vec_ready), .w_vec_inp(w_vec_inp),
        .w_vec_wgt(w_vec_wgt), .w_row_inp(w_row_inp), .w_col_wgt(w_col_wgt),
        .w_pe_ready(w_pe_ready), .w_pe_rw(w_pe_rw), .w_pe_stream(w_pe_stream),
        .w_capture(w_capture), .w_busy(w_busy), .w_done(w_done)
    );

    int total = 0;
    int bad   = 0;
    int t     = 0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", n, t, a, e);
        end
    endtask

    // Timeline model: a tile started at cycle s clears at s+1, feeds from s+2 until k
    // vectors are accepted, captures RC+2 cycles after the last acceptance, completes one later.
    bit                 in_tile = 1'b0, cap_known = 1'b0, busy_e, pe_e, rw_e, rdy_e, xf;
    int                 s = 0, k = 0, acc = 0, cap = 0;
    logic [ROWS*IW-1:0] h_inp [16];
    logic [COLS*WW-1:0] h_wgt [16];
    logic [ROWS*IW-1:0] er;
    logic [COLS*WW-1:0] ec;

    initial begin
        for (int i = 0; i < 16; i++) begin h_inp[i] = '0; h_wgt[i] = '0; end
        @(posedge w_clock);
        forever begin
            @(negedge w_clock);
            busy_e = in_tile && t > s;
            pe_e   = in_tile && t > s + 1;
            rw_e   = pe_e && !(cap_known && t >= cap);
            rdy_e  = pe_e && acc < k;
            for (int r = 0; r < ROWS; r++) er[r*IW +: IW] = rw_e ? h_inp[(t - r - 1) & 15][r*IW +: IW] : '0;
            for (int c = 0; c < COLS; c++) ec[c*WW +: WW] = rw_e ? h_wgt[(t - c - 1) & 15][c*WW +: WW] : '0;
            chk("busy", 64'(w_busy), 64'(busy_e));
            chk("pe_ready", 64'(w_pe_ready), 64'(pe_e));
            chk("pe_rw", 64'(w_pe_rw), 64'(rw_e));
            chk("pe_stream", 64'(w_pe_stream), 64'(0));
            chk("vec_ready", 64'(w_vec_ready), 64'(rdy_e));
            chk("capture", 64'(w_capture), 64'(in_tile && cap_known && t == cap));
            chk("done", 64'(w_done), 64'(in_tile && cap_known && t == cap + 1));
            chk("row_inp", 64'(w_row_inp), 64'(er));
            chk("col_wgt", 64'(w_col_wgt), 64'(ec));
            xf = rdy_e && w_vec_valid;
            h_inp[t & 15] = xf ? w_vec_inp : '0;
            h_wgt[t & 15] = xf ? w_vec_wgt : '0;
            if (xf) begin
                acc++;
                if (acc == k) begin cap = t + RC + 2; cap_known = 1'b1; end
            end
            if (in_tile && cap_known && t == cap + 1) in_tile = 1'b0;
            if (w_reset) begin
                in_tile = 1'b0;
                cap_known = 1'b0;
                for (int i = 0; i < 16; i++) begin h_inp[i] = '0; h_wgt[i] = '0; end
            end else if (!busy_e && w_start) begin
                in_tile   = 1'b1;
                s         = t;
                k         = (int'(w_k_len) > K_MAX) ? K_MAX : int'(w_k_len);
                acc       = 0;
                cap_known = (k == 0);
                cap       = t + 2;
            end
            t++;
        end
    end

    int            cap_at, done_at, n_xfer, ready_seen, pulses;
    logic          pe1, busy1;
    logic [IW-1:0] l0 [64];
    logic [IW-1:0] l1 [64];

    task automatic step();
        @(posedge w_clock);
        #1;
    endtask

    task automatic idle(input int n, output int p);
        p = 0;
        repeat (n) begin
            @(negedge w_clock);
            if (w_done || w_capture) p++;
            step();
        end
    endtask

    // Cycle 0 is the start cycle; inputs for cycle i are applied just after its opening edge
    task automatic run(input int klen, input int bub_lo, input int bub_hi, input bit rnd, input int maxc);
        int idx;
        bit x;
        idx = 0; cap_at = -1; done_at = -1; ready_seen = 0;
        w_start = 1'b1;
        w_k_len = KW'(klen);
        w_vec_valid = 1'b0;
        step();
        w_start = 1'b0;
        for (int i = 1; i <= maxc && done_at < 0; i++) begin
            w_vec_valid = rnd ? ($urandom_range(3) != 0) : !(i >= bub_lo && i <= bub_hi);
            for (int r = 0; r < ROWS; r++) w_vec_inp[r*IW +: IW] = rnd ? IW'($urandom) : IW'(2 * idx + r + 1);
            w_vec_wgt = (COLS*WW)'($urandom);
            if (rnd) begin
                w_start = ($urandom_range(7) == 0);
                w_k_len = KW'($urandom_range(0, 20));
            end
            @(negedge w_clock);
            if (w_capture) cap_at = i;
            if (w_done) done_at = i;
            if (w_vec_ready) ready_seen = 1;
            if (i < 64) begin l0[i] = w_row_inp[IW-1:0]; l1[i] = w_row_inp[2*IW-1:IW]; end
            if (i == 1) begin pe1 = w_pe_ready; busy1 = w_busy; end
            x = w_vec_ready && w_vec_valid;
            step();
            if (x) idx++;
        end
        w_start = 1'b0;
        w_vec_valid = 1'b0;
        n_xfer = idx;
        chk("run_done_seen", 64'(done_at >= 0), 64'(1));
    endtask

    initial begin
        int n;
        bit x;
        repeat (3) step();
        w_reset = 1'b0;
        @(negedge w_clock);
        chk("rst_busy", 64'(w_busy), 64'(0));
        chk("rst_pe_ready", 64'(w_pe_ready), 64'(0));
        chk("rst_row", 64'(w_row_inp), 64'(0));
        step();

        // reset in the middle of FEED
        w_start = 1'b1; w_k_len = KW'(4);
        step();
        w_start = 1'b0; w_vec_valid = 1'b1; n = 0;
        for (int i = 0; i < 10 && n < 2; i++) begin
            w_vec_inp = (ROWS*IW)'($urandom) | 1;
            w_vec_wgt = (COLS*WW)'($urandom) | 1;
            @(negedge w_clock);
            x = w_vec_ready;
            step();
            if (x) n++;
        end
        chk("rstfeed_xfers", 64'(n), 64'(2));
        w_reset = 1'b1; w_vec_valid = 1'b0;
        step();
        w_reset = 1'b0;
        @(negedge w_clock);
        chk("rstfeed_busy", 64'(w_busy), 64'(0));
        chk("rstfeed_pe_ready", 64'(w_pe_ready), 64'(0));
        chk("rstfeed_row", 64'(w_row_inp), 64'(0));
        chk("rstfeed_col", 64'(w_col_wgt), 64'(0));
        step();
        idle(20, pulses);
        chk("rstfeed_pulses", 64'(pulses), 64'(0));

        // k=3, no bubbles: vectors {1,2},{3,4},{5,6}
        run(3, 0, -1, 0, 40);
        chk("k3_capture", 64'(cap_at), 64'(10));
        chk("k3_done", 64'(done_at), 64'(11));
        chk("k3_clear_pe", 64'(pe1), 64'(0));
        chk("k3_clear_busy", 64'(busy1), 64'(1));
        chk("k3_l0", {l0[3], l0[4], l0[5]}, {8'd1, 8'd3, 8'd5});
        chk("k3_l1", {l1[4], l1[5], l1[6]}, {8'd2, 8'd4, 8'd6});

        // same tile with two bubbles after the first transfer
        run(3, 3, 4, 0, 40);
        chk("bub_capture", 64'(cap_at), 64'(12));
        chk("bub_l0", {l0[3], l0[4], l0[5], l0[6], l0[7]}, {8'd1, 8'd0, 8'd0, 8'd3, 8'd5});
        chk("bub_l1", {l1[4], l1[5], l1[6], l1[7], l1[8]}, {8'd2, 8'd0, 8'd0, 8'd4, 8'd6});

        // empty tile
        run(0, 0, -1, 0, 20);
        chk("k0_capture", 64'(cap_at), 64'(2));
        chk("k0_done", 64'(done_at), 64'(3));
        chk("k0_ready_seen", 64'(ready_seen), 64'(0));

        // oversize length is clamped to K_MAX
        run(K_MAX + 5, 0, -1, 0, 400);
        chk("kmax_xfers", 64'(n_xfer), 64'(K_MAX));
        chk("kmax_capture", 64'(cap_at), 64'(2 + K_MAX + RC + 1));

        // random bubbles, data and stray start pulses during tiles
        repeat (30) run($urandom_range(0, 12), 0, -1, 1, 200);
        run($urandom_range(250, 511), 0, -1, 1, 900);
        idle(8, pulses);
        chk("stray_start_pulses", 64'(pulses), 64'(0));

        // a fresh start from IDLE clears for one cycle
        run(2, 0, -1, 0, 30);
        chk("restart_clear_pe", 64'(pe1), 64'(0));
        chk("restart_clear_busy", 64'(busy1), 64'(1));
        chk("restart_capture", 64'(cap_at), 64'(9));

        repeat (2) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/out_skew_sequencer.md
Name: out_skew_sequencer

Overview:
- Upstream feeder and controller for the output-stationary PE array.
- Accepts one input vector (one element per array row) and one weight vector (one element per array column) per handshake.
- Applies diagonal systolic skew to both vectors and drives the array-wide control lines `w_pe_ready`, `w_pe_rw` and `w_pe_stream` through the clear, compute, flush and readout phases of one output tile.
- Flags the single cycle in which the PE scratchpads are visible on their outputs.

Parameters:
- ROWS, 4: array rows; one input lane per row.
- COLS, 4: array columns; one weight lane per column.
- OUT_PE_INPUT_WIDTH, `OUT_PE_INPUT_WIDTH`: input element width.
- OUT_PE_WEIGHT_WIDTH, `OUT_PE_WEIGHT_WIDTH`: weight element width.
- K_MAX, 256: maximum reduction length per tile.
- KW, $clog2(K_MAX+1): width of `w_k_len` and of the internal counters.

Ports:
- w_clock  in  1  clock.
- w_reset  in  1  synchronous, active-high reset.
- w_start  in  1  start-tile pulse; sampled only in IDLE.
- w_k_len  in  KW  reduction length; latched on an accepted start.
- w_vec_valid  in  1  upstream vector pair valid.
- w_vec_ready  out  1  sequencer accepts the vector pair this cycle.
- w_vec_inp  in  ROWS*OUT_PE_INPUT_WIDTH  input vector; element r is in bits [r*W +: W].
- w_vec_wgt  in  COLS*OUT_PE_WEIGHT_WIDTH  weight vector; element c is in bits [c*W +: W].
- w_row_inp  out  ROWS*OUT_PE_INPUT_WIDTH  skewed inputs to the left array edge.
- w_col_wgt  out  COLS*OUT_PE_WEIGHT_WIDTH  skewed weights to the top array edge.
- w_pe_ready  out  1  array enable; 0 clears the PE accumulators.
- w_pe_rw  out  1  1 = multiply-accumulate; 0 = hold and expose state.
- w_pe_stream  out  1  PE stream select; always 0 in this revision.
- w_capture  out  1  one-cycle pulse: PE outputs carry scratchpad values.
- w_busy  out  1  high in every state except IDLE.
- w_done  out  1  one-cycle pulse marking tile completion.

Behaviour:
- All outputs are registered.
- Reset (w_reset=1 at a clock edge):
  - state goes to IDLE.
  - all skew lanes, counters and outputs go to 0.
  - This applies in any state, including mid-tile; a partially fed tile is discarded and no `w_done` is produced.
- States: IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE.
- IDLE:
  - outputs: pe_ready=0, rw=0, vec_ready=0, busy=0.
  - On w_start=1: latch k = min(w_k_len, K_MAX) and go to CLEAR.
- CLEAR:
  - lasts 1 cycle with pe_ready=0, guaranteeing the accumulators are zeroed.
  - Next state is FEED if k>0, else DRAIN.
- FEED:
  - outputs: pe_ready=1, rw=1.
  - vec_ready=1 while accepted count < k.
  - A transfer happens on valid&&ready; the count increments on each transfer.
  - Go to FLUSH in the cycle after the k-th transfer.
  - valid=0 inserts a bubble (all-zero element into each lane).
  - vec_ready deasserts in the cycle after the k-th transfer.
- Skew, applied every cycle in FEED and FLUSH:
  - Row lane r is an (r+1)-deep shift register: w_row_inp[r] equals element r of the vector transferred r+1 cycles earlier, or 0 if no transfer occurred then.
  - Column lane c is identical with depth c+1.
  - In all other states the lane inputs are 0.
- FLUSH:
  - lasts exactly ROWS+COLS+1 cycles (covers array traversal plus the PE two-stage multiply/add), with pe_ready=1, rw=1.
  - A down-counter is loaded on entry.
  - Go to DRAIN when the counter reaches 0.
- DRAIN:
  - lasts 1 cycle with pe_ready=1, rw=0, stream=0 and w_capture=1.
  - The lane outputs are 0 during this cycle.
- DONE:
  - lasts 1 cycle with w_done=1 and pe_ready=1, rw=0.
  - Returns to IDLE; the accumulators clear on the next cycle via pe_ready=0.
- w_start is ignored outside IDLE.
- A start pulse in the same cycle as the DONE→IDLE transition is not seen; it must arrive in IDLE.
- Simultaneous reset and start: reset wins.
- Total latency from the start cycle to the w_capture cycle with no bubbles is 1 + 1 + k + (ROWS+COLS+1) cycles; each bubble adds 1 cycle.

Test Plan:
- Reset mid-FEED (ROWS=COLS=2, k=4, after 2 transfers) -> next cycle: busy=0, all lanes 0, pe_ready=0; no done/capture pulse ever appears.
- ROWS=COLS=2, start with k=3, valid held high, inp vectors {1,2},{3,4},{5,6}:
  - w_row_inp[0] shows 1,3,5 on consecutive cycles starting 1 cycle after the first transfer.
  - w_row_inp[1] shows 2,4,6 starting 2 cycles after the first transfer.
  - w_capture rises exactly 1+1+3+5 = 10 cycles after start; w_done follows 1 cycle later.
- Same tile with valid=0 for 2 cycles after the first transfer -> two zero entries are inserted in every lane; w_capture is delayed by exactly 2 cycles.
- k_len=0 -> CLEAR then DRAIN; w_capture at cycle 2 and w_done at cycle 3; vec_ready never asserts.
- k_len = K_MAX+5 -> exactly K_MAX transfers accepted; vec_ready deasserts after the K_MAX-th.
- w_start pulsed during FEED and FLUSH -> ignored; only one w_done is produced; a second start in IDLE begins a new tile with CLEAR (pe_ready=0) for 1 cycle.
